// File: rtl/interp_pkg.sv
// Shared types and helpers for the polyphase interpolating FIR: FSM states,
// accumulator width and the generic round/saturate function.
package interp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Working width for rounding/saturation; wide enough for any legal accumulator.
    localparam int RS_W = 128;

    typedef struct {
        logic signed [RS_W-1:0] value;
        logic                   clip;
    } rs_t;

    function automatic int acc_width(input int iw, input int cw, input int taps);
        return iw + cw + $clog2(taps);
    endfunction

    function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                      input int shift, input int out_w);
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] rnd;
        logic signed [RS_W-1:0] max_v;
        logic signed [RS_W-1:0] min_v;
        rs_t                    r;
        one = RS_W'(1);
        rnd = acc;
        // Adding half an LSB before the arithmetic shift rounds ties upward.
        if (shift > 0) begin
            rnd = (acc + (one <<< (shift - 1))) >>> shift;
        end
        max_v   = (one <<< (out_w - 1)) - one;
        min_v   = -(one <<< (out_w - 1));
        r.value = rnd;
        r.clip  = 1'b0;
        if (rnd > max_v) begin
            r.value = max_v;
            r.clip  = 1'b1;
        end else if (rnd < min_v) begin
            r.value = min_v;
            r.clip  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sat_round.sv
// Scales the full-precision accumulator down to the output width:
// arithmetic shift with round-half-up, then signed saturation.
module fir_sat_round
    import interp_pkg::*;
#(
    parameter int ACC_W            = 37,
    parameter int OUT_SHIFT        = 0,
    parameter int OUTPUT_WORD_SIZE = 16
) (
    input  logic signed [ACC_W-1:0]            acc,
    output logic signed [OUTPUT_WORD_SIZE-1:0] value,
    output logic                               clip
);

    logic signed [RS_W-1:0] acc_ext;
    rs_t                    rs;

    assign acc_ext = RS_W'(acc);

    always_comb begin
        rs    = round_sat(acc_ext, OUT_SHIFT, OUTPUT_WORD_SIZE);
        value = OUTPUT_WORD_SIZE'(rs.value);
        clip  = rs.clip;
    end

endmodule

// File: rtl/polyphase_interp_fir.sv
// Polyphase interpolate-by-L FIR: each accepted sample yields L outputs, phase p
// computed as sum_k x[k]*h[k*L+p] with a ready/valid handshake on both sides.
module polyphase_interp_fir
    import interp_pkg::*;
#(
    parameter int INPUT_WORD_SIZE  = 16,
    parameter int COEFF_WORD_SIZE  = 16,
    parameter int INTERP_FACTOR    = 4,
    parameter int TAPS_PER_PHASE   = 4,
    parameter int OUT_SHIFT        = 0,
    parameter int OUTPUT_WORD_SIZE = 16
) (
    input  logic                                                        clk,
    input  logic                                                        arst_n,
    input  logic [INTERP_FACTOR*TAPS_PER_PHASE*COEFF_WORD_SIZE-1:0]     coeff,
    input  logic signed [INPUT_WORD_SIZE-1:0]                           data_in,
    input  logic                                                        valid_in,
    output logic                                                        ready_in,
    output logic signed [OUTPUT_WORD_SIZE-1:0]                          data_out,
    output logic                                                        valid_out,
    input  logic                                                        ready_out,
    output logic                                                        sat_out
);

    localparam int L      = INTERP_FACTOR;
    localparam int T      = TAPS_PER_PHASE;
    localparam int IW     = INPUT_WORD_SIZE;
    localparam int CW     = COEFF_WORD_SIZE;
    localparam int OW     = OUTPUT_WORD_SIZE;
    localparam int PROD_W = IW + CW;
    localparam int ACC_W  = acc_width(IW, CW, T);
    localparam int PH_W   = $clog2(L);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(L - 1);

    state_t                   state_reg, state_next;
    logic [PH_W-1:0]          phase_reg, phase_next;
    logic signed [IW-1:0]     x_reg  [T];
    logic signed [IW-1:0]     x_next [T];
    logic signed [CW-1:0]     h_tap  [T][L];
    logic signed [PROD_W-1:0] prod   [T];
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [OW-1:0]     sr_value;
    logic                     sr_clip;
    logic signed [OW-1:0]     data_out_reg;
    logic                     sat_reg;
    logic                     accept;
    logic                     load;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        ready_in   = 1'b0;
        load       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    state_next = EMIT;
                    phase_next = '0;
                    load       = 1'b1;
                end
            end
            EMIT: begin
                if (ready_out) begin
                    if (phase_reg == LAST_PHASE) begin
                        // Last phase leaving: a waiting sample restarts phase 0 with no bubble.
                        ready_in   = 1'b1;
                        phase_next = '0;
                        if (valid_in) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        phase_next = phase_reg + PH_W'(1);
                        load       = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = valid_in & ready_in;

    // The MAC looks at the delay line and phase as they will be after this edge,
    // so the registered output lines up with the new state.
    genvar gi, gj;
    generate
        for (gi = 0; gi < T; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign x_next[gi] = accept ? data_in : x_reg[gi];
            end else begin : g_shift
                assign x_next[gi] = accept ? x_reg[gi-1] : x_reg[gi];
            end
            for (gj = 0; gj < L; gj++) begin : g_phase
                assign h_tap[gi][gj] = coeff[(gi*L+gj)*CW +: CW];
            end
            assign prod[gi] = PROD_W'(x_next[gi]) * PROD_W'(h_tap[gi][phase_next]);
        end
    endgenerate

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < T; k++) begin
            acc_sum = acc_sum + ACC_W'(prod[k]);
        end
    end

    fir_sat_round #(
        .ACC_W            (ACC_W),
        .OUT_SHIFT        (OUT_SHIFT),
        .OUTPUT_WORD_SIZE (OW)
    ) u_sat_round (
        .acc   (acc_sum),
        .value (sr_value),
        .clip  (sr_clip)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            data_out_reg <= '0;
            sat_reg      <= 1'b0;
            for (int k = 0; k < T; k++) begin
                x_reg[k] <= '0;
            end
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            x_reg     <= x_next;
            if (load) begin
                data_out_reg <= sr_value;
                sat_reg      <= sr_clip;
            end else if (state_next == IDLE) begin
                sat_reg <= 1'b0;
            end
        end
    end

    assign data_out  = data_out_reg;
    assign sat_out   = sat_reg;
    assign valid_out = (state_reg == EMIT);

endmodule
